// File: rtl/battleship_pkg.sv
// Shared types for the battleship game controller: state encoding and ship-count type.
package battleship_pkg;

    localparam int unsigned SHIP_W        = 3;
    localparam int unsigned SEC_W         = 4;
    localparam int unsigned MAX_SHIPS_DEF = 5;

    typedef logic [SHIP_W-1:0] ship_cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PLACE       = 3'd1,
        ST_ENEMY_PLACE = 3'd2,
        ST_PLAYER_TURN = 3'd3,
        ST_ENEMY_TURN  = 3'd4,
        ST_WIN         = 3'd5,
        ST_LOSE        = 3'd6
    } state_e;

endpackage

// File: rtl/battleship_game_ctrl_turn_timer.sv
// Player turn countdown: a TICKS_PER_SEC prescaler and a seconds counter that flags a
// timeout on the wrap that finds the seconds counter already at zero.
module turn_timer
    import battleship_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned TURN_SECONDS  = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_en,
    output logic [SEC_W-1:0] o_seconds,
    output logic             o_timeout_c
);

    localparam int unsigned PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    logic [PRESC_W-1:0] r_presc;
    logic [SEC_W-1:0]   r_seconds;
    logic               w_wrap;

    assign w_wrap      = i_en && (r_presc == PRESC_W'(TICKS_PER_SEC - 1));
    assign o_timeout_c = w_wrap && (r_seconds == '0);
    assign o_seconds   = r_seconds;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc   <= '0;
            r_seconds <= '0;
        end else if (i_load) begin
            r_presc   <= '0;
            r_seconds <= SEC_W'(TURN_SECONDS);
        end else if (i_en) begin
            if (w_wrap) begin
                r_presc <= '0;
                if (r_seconds != '0) begin
                    r_seconds <= r_seconds - SEC_W'(1);
                end
            end else begin
                r_presc <= r_presc + PRESC_W'(1);
            end
        end
    end

endmodule

// File: rtl/battleship_game_ctrl.sv
// Battleship game sequencer: amount decision, placement, alternating turns, win/lose.
// Optional turn time limit enabled by defining BATTLESHIP_TURN_TIMEOUT_EN.
module battleship_game_ctrl
    import battleship_pkg::*;
#(
    parameter int unsigned MAX_SHIPS     = MAX_SHIPS_DEF,
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned TURN_SECONDS  = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ships_decided,
    input  logic [2:0]       player_amount_ships,
    input  logic             place_confirm,
    input  logic             place_valid,
    input  logic             enemy_place_done,
    input  logic             player_shot_done,
    input  logic             player_sunk,
    input  logic             enemy_shot_done,
    input  logic             enemy_sunk,
    input  logic             new_game,
    output logic             amount_en,
    output logic             place_en,
    output logic             enemy_place_start,
    output logic             player_turn,
    output logic             enemy_turn,
    output logic             game_over,
    output logic             player_won,
    output logic [2:0]       fleet_size,
    output logic [2:0]       ships_placed,
    output logic [2:0]       player_left,
    output logic [2:0]       enemy_left,
    output logic [SEC_W-1:0] seconds_left,
    output logic [2:0]       state_o
);

    state_e    r_state;
    ship_cnt_t r_fleet_size;
    ship_cnt_t r_ships_placed;
    ship_cnt_t r_player_left;
    ship_cnt_t r_enemy_left;
    logic      r_enemy_place_start;

    logic      w_amount_ok;
    logic      w_to_player;
    logic      w_timeout;
    ship_cnt_t w_placed_inc;

    assign w_amount_ok  = (player_amount_ships != '0) &&
                          (32'(player_amount_ships) <= MAX_SHIPS);
    assign w_placed_inc = r_ships_placed + ship_cnt_t'(1);

    // Entry into PLAYER_TURN; also reloads the turn timer on the same edge.
    assign w_to_player = ((r_state == ST_ENEMY_PLACE) && enemy_place_done) ||
                         ((r_state == ST_ENEMY_TURN) && enemy_shot_done &&
                          !(enemy_sunk && (r_player_left == ship_cnt_t'(1))));

`ifdef BATTLESHIP_TURN_TIMEOUT_EN
    logic [SEC_W-1:0] w_seconds;

    turn_timer #(
        .TICKS_PER_SEC (TICKS_PER_SEC),
        .TURN_SECONDS  (TURN_SECONDS)
    ) u_turn_timer (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_to_player),
        .i_en        (r_state == ST_PLAYER_TURN),
        .o_seconds   (w_seconds),
        .o_timeout_c (w_timeout)
    );

    assign seconds_left = w_seconds;
`else
    assign w_timeout    = 1'b0;
    assign seconds_left = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state             <= ST_IDLE;
            r_fleet_size        <= '0;
            r_ships_placed      <= '0;
            r_player_left       <= '0;
            r_enemy_left        <= '0;
            r_enemy_place_start <= 1'b0;
        end else begin
            r_enemy_place_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (ships_decided && w_amount_ok) begin
                        r_fleet_size   <= player_amount_ships;
                        r_player_left  <= player_amount_ships;
                        r_enemy_left   <= player_amount_ships;
                        r_ships_placed <= '0;
                        r_state        <= ST_PLACE;
                    end
                end
                ST_PLACE: begin
                    if (place_confirm && place_valid) begin
                        r_ships_placed <= w_placed_inc;
                        if (w_placed_inc == r_fleet_size) begin
                            r_state             <= ST_ENEMY_PLACE;
                            r_enemy_place_start <= 1'b1;
                        end
                    end
                end
                ST_ENEMY_PLACE: begin
                    if (enemy_place_done) begin
                        r_state <= ST_PLAYER_TURN;
                    end
                end
                // A shot resolving on the timeout cycle takes priority over the forfeit.
                ST_PLAYER_TURN: begin
                    if (player_shot_done) begin
                        if (player_sunk && (r_enemy_left != '0)) begin
                            r_enemy_left <= r_enemy_left - ship_cnt_t'(1);
                            r_state      <= (r_enemy_left == ship_cnt_t'(1)) ? ST_WIN : ST_ENEMY_TURN;
                        end else begin
                            r_state <= ST_ENEMY_TURN;
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_ENEMY_TURN;
                    end
                end
                ST_ENEMY_TURN: begin
                    if (enemy_shot_done) begin
                        if (enemy_sunk && (r_player_left != '0)) begin
                            r_player_left <= r_player_left - ship_cnt_t'(1);
                            r_state       <= (r_player_left == ship_cnt_t'(1)) ? ST_LOSE : ST_PLAYER_TURN;
                        end else begin
                            r_state <= ST_PLAYER_TURN;
                        end
                    end
                end
                ST_WIN, ST_LOSE: begin
                    if (new_game) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign amount_en         = (r_state == ST_IDLE);
    assign place_en          = (r_state == ST_PLACE);
    assign enemy_place_start = r_enemy_place_start;
    assign player_turn       = (r_state == ST_PLAYER_TURN);
    assign enemy_turn        = (r_state == ST_ENEMY_TURN);
    assign game_over         = (r_state == ST_WIN) || (r_state == ST_LOSE);
    assign player_won        = (r_state == ST_WIN);
    assign fleet_size        = r_fleet_size;
    assign ships_placed      = r_ships_placed;
    assign player_left       = r_player_left;
    assign enemy_left        = r_enemy_left;
    assign state_o           = r_state;

endmodule

// File: doc/battleship_game_ctrl.md
# battleship_game_ctrl

Top-level game sequencer for the battleship lab. It enables the ship-amount decision stage and latches the agreed fleet size when `ships_decided` asserts. It then steps through player placement, enemy placement and alternating firing turns until one fleet is sunk. It sits above the amount-decision, placement and shot-resolution blocks and only exchanges enables, done pulses and status with them.

## Interface
- `MAX_SHIPS`, default 5: largest legal fleet size; amounts 1..MAX_SHIPS are accepted.
- `TICKS_PER_SEC`, default 50_000_000: clk cycles per one-second tick.
- `TURN_SECONDS`, default 15: player turn time limit (used only with the timeout feature).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `ships_decided` in 1: amount-decision stage reports an agreed amount (level).
- `player_amount_ships` in 3: agreed fleet size; sampled with `ships_decided`.
- `place_confirm` in 1: player confirms one ship placement (1-cycle pulse).
- `place_valid` in 1: current placement is legal; qualifies `place_confirm`.
- `enemy_place_done` in 1: enemy placement finished (pulse).
- `player_shot_done` in 1: player shot resolved (pulse).
- `player_sunk` in 1: that shot sank an enemy ship; valid only with `player_shot_done`.
- `enemy_shot_done` in 1: enemy shot resolved (pulse).
- `enemy_sunk` in 1: that shot sank a player ship; valid only with `enemy_shot_done`.
- `new_game` in 1: restart from a finished game.
- `amount_en` out 1: enables the amount-decision stage.
- `place_en` out 1: player placement active.
- `enemy_place_start` out 1: 1-cycle pulse on entry to enemy placement.
- `player_turn` out 1: player may fire.
- `enemy_turn` out 1: enemy may fire.
- `game_over` out 1: game finished.
- `player_won` out 1: valid while `game_over` is high.
- `fleet_size` out 3: latched amount.
- `ships_placed` out 3: player ships placed so far.
- `player_left` out 3: player ships afloat.
- `enemy_left` out 3: enemy ships afloat.
- `seconds_left` out 4: remaining player turn time; 0 when the timeout feature is compiled out.
- `state_o` out 3: current state encoding, for debug.

## Operation
- IDLE (`amount_en`=1):
  - `ships_decided` with an amount of 1..MAX_SHIPS latches `fleet_size`, loads `player_left` and `enemy_left` with the amount, clears `ships_placed`, and goes to PLACE.
  - An amount of 0 or greater than MAX_SHIPS is ignored; the block stays in IDLE.
- PLACE (`place_en`=1):
  - `place_confirm && place_valid` increments `ships_placed`.
  - `place_confirm` with `!place_valid` is ignored.
  - The confirm that makes `ships_placed == fleet_size` goes to ENEMY_PLACE.
- ENEMY_PLACE: `enemy_place_start` pulses on the first cycle of the state. `enemy_place_done` goes to PLAYER_TURN.
- PLAYER_TURN (`player_turn`=1): on `player_shot_done`:
  - If `player_sunk`, `enemy_left` decrements.
  - If the decrement reaches 0, go to WIN; otherwise go to ENEMY_TURN.
- ENEMY_TURN (`enemy_turn`=1): on `enemy_shot_done`:
  - If `enemy_sunk`, `player_left` decrements.
  - If the decrement reaches 0, go to LOSE; otherwise go to PLAYER_TURN.
- WIN / LOSE: `game_over`=1; `player_won` is 1 in WIN and 0 in LOSE. `new_game` goes to IDLE. Counters hold until the next latch in IDLE.
- Done and sunk pulses arriving outside their own state are ignored.
- Counters never underflow; a sunk indication at 0 is ignored.

## Timing
- Reset values:
  - State is IDLE, so `amount_en`=1.
  - All other 1-bit outputs are 0.
  - All counters are 0; `seconds_left` is 0.
- All state transitions take effect one cycle after the qualifying input is sampled.
- Enable outputs are decoded from the registered state (Moore), with no combinational input-to-output paths.
- `rst` mid-game overrides every input and returns the block to its reset values on the next edge.
- With the timeout feature, if `player_shot_done` and the timeout coincide, the shot wins.

## Configuration
- `BATTLESHIP_TURN_TIMEOUT_EN` defined:
  - On entry to PLAYER_TURN, `seconds_left` loads TURN_SECONDS and the tick prescaler clears.
  - Each prescaler wrap (TICKS_PER_SEC cycles) decrements `seconds_left`.
  - A wrap while `seconds_left` is 0 forfeits the turn: go to ENEMY_TURN with no counter change.
- Not defined: no prescaler or timer logic exists, `seconds_left` is tied to 0, and PLAYER_TURN waits indefinitely.

## Structure
- `battleship_pkg` holds:
  - The state enum: IDLE=0, PLACE=1, ENEMY_PLACE=2, PLAYER_TURN=3, ENEMY_TURN=4, WIN=5, LOSE=6.
  - The `MAX_SHIPS` default and the 3-bit ship-count typedef.
- One sub-module, `turn_timer`, contains the prescaler and the seconds countdown. It has load, enable and timeout ports and is instantiated only under the macro.

## Test plan
- Reset, then `ships_decided`=1 with amount 0, then amount 6 -> stays IDLE with `amount_en`=1. Then amount 3 -> PLACE, `fleet_size`=3, `player_left`=`enemy_left`=3.
- In PLACE, 3 confirms with the second having `place_valid`=0:
  - `ships_placed` goes 1, 1, 2.
  - A 4th valid confirm -> ENEMY_PLACE, with `enemy_place_start` high for exactly 1 cycle.
- Fleet 1:
  - `enemy_place_done`, then `player_shot_done` with `player_sunk`=0 -> ENEMY_TURN.
  - `enemy_shot_done` -> PLAYER_TURN.
  - `player_shot_done` with `player_sunk`=1 -> WIN, `game_over`=1, `player_won`=1.
  - `new_game` -> IDLE.
- Fleet 2, enemy sinks twice -> LOSE, `player_won`=0, `enemy_left`=2.
- `rst` asserted in ENEMY_TURN with `enemy_shot_done` in the same cycle -> IDLE, all counters 0.
- Macro defined, TICKS_PER_SEC=4, TURN_SECONDS=3, no shot:
  - `seconds_left` steps 3, 2, 1, 0 every 4 cycles; the next wrap goes to ENEMY_TURN.
  - `player_shot_done` on the timeout cycle -> the shot is processed and the timeout is ignored.
